stream_arb_mux: RTL and testbench

Parametrised N-channel, W-bit stream multiplexer that supersedes the fixed two-input, unregistered select muxes in the hardware library. Selection is made by an internal arbiter (round-robin or fixed priority), not by an external select. Arbitration locks per packet. Transfers use valid/ready handshakes. The output is a single registered stage. It sits wherever several producers (bus masters, debug/UART sources, DMA channels) share one downstream sink.

---
 rtl/mux_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/stream_arb_mux.sv | 117 +++++++++++
 tb/tb_stream_arb_mux.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the stream arbitration multiplexer.
//   state_e : packet-level arbitration state (IDLE = free to arbitrate,
//             LOCK = grant pinned to one channel until its last beat)
//   selw()  : width of a channel index, at least 1 bit even for one channel
package mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  function automatic int selw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter, reusable for any shared resource.
// Ports:
//   req_i     : per-requester request
//   ptr_i     : round-robin base; search starts at ptr_i+1 and wraps modulo NCH
//   rr_mode_i : 1 = round-robin from ptr_i, 0 = fixed priority (lowest index wins)
//   gnt_o     : one-hot grant (all zero when nothing requests)
//   idx_o     : encoded index of the granted requester (0 when none)
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = selw(NCH)
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [SELW-1:0] ptr_i,
  input  logic            rr_mode_i,
  output logic [NCH-1:0]  gnt_o,
  output logic [SELW-1:0] idx_o
);

  int   cand;
  logic found;

  // Walk all NCH candidates in priority order; the first requester wins.
  // The wrap is an explicit modulo so non-power-of-two NCH never visits
  // an index outside 0..NCH-1.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NCH; k++) begin
      if (rr_mode_i) cand = (int'(ptr_i) + k) % NCH;
      else           cand = k - 1;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-channel valid/ready stream multiplexer with an internal arbiter that
// locks onto a channel for the duration of a packet, feeding one
// registered output stage.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : per-channel beat valid
//   in_data    : channel i at bits [i*WIDTH +: WIDTH]
//   in_last    : per-channel end-of-packet
//   in_ready   : per-channel accept (at most one bit high)
//   out_valid  : output register holds a beat
//   out_data   : registered beat data
//   out_last   : registered end-of-packet
//   out_sel    : source channel of the registered beat
//   out_ready  : sink accept
module stream_arb_mux
  import mux_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int WIDTH = 32,
  parameter  int RR    = 1,
  localparam int SELW  = selw(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_last,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  state_e            state_q;
  logic [SELW-1:0]   lock_ch_q;
  logic [SELW-1:0]   ptr_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic              out_last_q;
  logic [SELW-1:0]   out_sel_q;

  logic [NCH-1:0]    arb_gnt;
  logic [SELW-1:0]   arb_idx;
  logic [NCH-1:0]    grant;
  logic              load;
  logic              accept;
  logic [SELW-1:0]   sel_d;
  logic [WIDTH-1:0]  data_d;
  logic              last_d;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req_i     (in_valid),
    .ptr_i     (ptr_q),
    .rr_mode_i (RR != 0),
    .gnt_o     (arb_gnt),
    .idx_o     (arb_idx)
  );

  always_comb begin
    // Output register can take a beat when empty or draining this edge.
    load = !out_valid_q || out_ready;
    // While locked the grant stays on the packet owner even if it pauses,
    // so no other channel can slip a beat into the middle of a packet.
    if (state_q == LOCK) begin
      grant = NCH'(1) << lock_ch_q;
      sel_d = lock_ch_q;
    end else begin
      grant = arb_gnt;
      sel_d = arb_idx;
    end
    in_ready = grant & {NCH{load}};
    accept   = |(in_valid & in_ready);
    data_d   = in_data[int'(sel_d)*WIDTH +: WIDTH];
    last_d   = in_last[sel_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_ch_q   <= '0;
      ptr_q       <= SELW'(NCH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      if (load) begin
        out_valid_q <= accept;
        if (accept) begin
          out_data_q <= data_d;
          out_last_q <= last_d;
          out_sel_q  <= sel_d;
        end
      end
      if (accept) begin
        if (last_d) begin
          state_q <= IDLE;
          ptr_q   <= sel_d;
        end else begin
          state_q   <= LOCK;
          lock_ch_q <= sel_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
module tb_stream_arb_mux;

  localparam int NCH = 4;
  localparam int W   = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   in_valid;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_last;
  logic             out_ready;

  logic [NCH-1:0] ir_a, ir_b;
  logic           ov_a, ov_b, ol_a, ol_b;
  logic [W-1:0]   od_a, od_b;
  logic [1:0]     os_a, os_b;

  always #5 clk = ~clk;

  stream_arb_mux #(.NCH(NCH), .WIDTH(W), .RR(1)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(ir_a), .out_valid(ov_a), .out_data(od_a),
    .out_last(ol_a), .out_sel(os_a), .out_ready(out_ready)
  );

  stream_arb_mux #(.NCH(NCH), .WIDTH(W), .RR(0)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(ir_b), .out_valid(ov_b), .out_data(od_b),
    .out_last(ol_b), .out_sel(os_b), .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model (index 0 = round-robin, 1 = fixed) --
  bit          mlock[2];
  int          mlch[2];
  int          mptr[2];
  bit          mov[2];
  logic [W-1:0] mod[2];
  bit          mol[2];
  int          mos[2];

  task automatic model_reset(input int m);
    mlock[m] = 1'b0; mlch[m] = 0; mptr[m] = NCH - 1;
    mov[m] = 1'b0; mod[m] = '0; mol[m] = 1'b0; mos[m] = 0;
  endtask

  task automatic step_model(input int m, input logic [3:0] ir, input logic ovv,
                            input logic [W-1:0] odv, input logic olv, input logic [1:0] osv);
    int g, c;
    bit ld, acc;
    logic [3:0] er;
    string t;
    t = (m == 0) ? "rr" : "fp";
    g = -1;
    if (mlock[m]) g = mlch[m];
    else if (m == 0) begin
      for (int k = 1; k <= NCH; k++) begin
        c = (mptr[m] + k) % NCH;
        if (g < 0 && in_valid[c]) g = c;
      end
    end else begin
      for (int k = 0; k < NCH; k++) if (g < 0 && in_valid[k]) g = k;
    end
    ld = !mov[m] || out_ready;
    er = (g >= 0 && ld) ? (4'b1 << g) : 4'b0;
    chk({t, " in_ready"}, ir, er);
    chk({t, " out_valid"}, ovv, mov[m]);
    chk({t, " out_data"}, odv, mod[m]);
    chk({t, " out_last"}, olv, mol[m]);
    chk({t, " out_sel"}, osv, mos[m]);
    if (rst) model_reset(m);
    else begin
      acc = (g >= 0) && ld && in_valid[g];
      if (ld) mov[m] = acc;
      if (acc) begin
        mod[m] = in_data[g*W +: W];
        mol[m] = in_last[g];
        mos[m] = g;
        if (in_last[g]) begin mlock[m] = 1'b0; mptr[m] = g; end
        else begin mlock[m] = 1'b1; mlch[m] = g; end
      end
    end
  endtask

  // ---------------- compare process + transfer logs ----------------------
  bit         fol = 1'b0;
  logic [3:0] rdy_s = '0;
  int         lsel_a[$], lsel_b[$], lcyc_a[$];
  bit         llast_a[$];

  initial begin
    @(posedge clk);
    model_reset(0);
    model_reset(1);
    forever begin
      @(negedge clk);
      cyc++;
      step_model(0, ir_a, ov_a, od_a, ol_a, os_a);
      step_model(1, ir_b, ov_b, od_b, ol_b, os_b);
      if (ov_a && out_ready) begin
        lsel_a.push_back(int'(os_a)); llast_a.push_back(ol_a); lcyc_a.push_back(cyc);
      end
      if (ov_b && out_ready) lsel_b.push_back(int'(os_b));
      rdy_s = fol ? ir_b : ir_a;
    end
  end

  // ---------------- sources ----------------------------------------------
  int         bcnt[NCH];
  int         plen[NCH];
  logic [3:0] en;

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      in_valid[c]        = en[c];
      in_data[c*W +: W]  = {8'(c), 24'(bcnt[c])};
      in_last[c]         = (bcnt[c] % plen[c]) == plen[c] - 1;
    end
  endtask

  task automatic tick();
    logic [3:0] acc;
    @(posedge clk);
    acc = in_valid & rdy_s;
    #1;
    for (int c = 0; c < NCH; c++) if (acc[c]) bcnt[c]++;
    drive();
  endtask

  task automatic do_reset();
    en  = '0;
    rst = 1'b1;
    drive();
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) begin bcnt[c] = 0; plen[c] = 1; end
    drive();
    lsel_a.delete(); lsel_b.delete(); lcyc_a.delete(); llast_a.delete();
  endtask

  function automatic int qa(input int i);
    return (i < lsel_a.size()) ? lsel_a[i] : -1;
  endfunction

  function automatic int qb(input int i);
    return (i < lsel_b.size()) ? lsel_b[i] : -1;
  endfunction

  function automatic int la(input int i);
    return (i < llast_a.size()) ? int'(llast_a[i]) : -1;
  endfunction

  int         exp_sel[8];
  int         exp_lst[4];
  logic [W-1:0] sd;
  logic [1:0]   ss;

  initial begin
    rst = 1'b1; out_ready = 1'b1; en = '0;
    for (int c = 0; c < NCH; c++) begin bcnt[c] = 0; plen[c] = 1; end
    drive();
    do_reset();
    chk("reset out_valid", ov_a, 1'b0);
    chk("reset out_data", od_a, 32'h0);
    chk("reset out_sel", os_a, 2'd0);
    chk("reset out_last", ol_a, 1'b0);

    // single channel 3-beat packet on ch2
    plen[2] = 3; en = 4'b0100; drive();
    #1 chk("t1 ready before accept", ir_a, 4'b0100);
    tick();
    chk("t1 first beat valid", ov_a, 1'b1);
    chk("t1 first beat sel", os_a, 2'd2);
    chk("t1 first beat data", od_a, 32'h0200_0000);
    tick(); tick();
    en = '0; drive();
    tick(); tick();
    chk("t1 beat count", lsel_a.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("t1 sel%0d", i), qa(i), 2);
    chk("t1 last0", la(0), 0);
    chk("t1 last1", la(1), 0);
    chk("t1 last2", la(2), 1);
    if (lcyc_a.size() >= 3) begin
      chk("t1 consecutive 1", lcyc_a[1] - lcyc_a[0], 1);
      chk("t1 consecutive 2", lcyc_a[2] - lcyc_a[1], 1);
    end else chk("t1 cycle log", lcyc_a.size(), 3);

    // fairness: all valid, 1-beat packets
    do_reset();
    en = 4'b1111; drive();
    repeat (8) tick();
    en = '0; drive();
    tick(); tick();
    exp_sel = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk("t2 beat count", lsel_a.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t2 sel%0d", i), qa(i), exp_sel[i]);

    // fixed priority: ch1 and ch3 valid, ch1 drops later
    fol = 1'b1;
    do_reset();
    en = 4'b1010; drive();
    repeat (5) tick();
    en = 4'b1000; drive();
    repeat (3) tick();
    en = '0; drive();
    tick(); tick();
    chk("t3 beat count", lsel_b.size(), 8);
    for (int i = 0; i < 5; i++) chk($sformatf("t3 ch1 beat%0d", i), qb(i), 1);
    for (int i = 5; i < 8; i++) chk($sformatf("t3 ch3 beat%0d", i), qb(i), 3);
    fol = 1'b0;

    // packet lock: ch0 pauses mid-packet while ch1 waits
    do_reset();
    plen[0] = 3; en = 4'b0001; drive();
    tick();
    en = 4'b0010; drive();
    #1 chk("t4 ch1 blocked a", ir_a[1], 1'b0);
    tick();
    chk("t4 ch1 blocked b", ir_a[1], 1'b0);
    tick();
    en = 4'b0011; drive();
    tick(); tick();
    en = 4'b0010; drive();
    tick();
    en = '0; drive();
    tick(); tick();
    exp_sel[0:3] = '{0, 0, 0, 1};
    exp_lst = '{0, 0, 1, 1};
    chk("t4 beat count", lsel_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4 sel%0d", i), qa(i), exp_sel[i]);
      chk($sformatf("t4 last%0d", i), la(i), exp_lst[i]);
    end

    // backpressure with output full
    do_reset();
    en = 4'b0100; drive();
    repeat (3) tick();
    out_ready = 1'b0;
    sd = od_a; ss = os_a;
    chk("t5 held data", sd, 32'h0200_0002);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t5 data stable%0d", i), od_a, sd);
      chk($sformatf("t5 sel stable%0d", i), os_a, ss);
      chk($sformatf("t5 ready low%0d", i), ir_a, 4'b0000);
    end
    out_ready = 1'b1;
    tick();
    chk("t5 no bubble valid", ov_a, 1'b1);
    chk("t5 next beat", od_a, 32'h0200_0003);
    en = '0; drive();
    tick(); tick();

    // reset while ch3 holds the lock
    do_reset();
    plen[3] = 4; en = 4'b1000; drive();
    tick(); tick();
    en = 4'b1111; drive();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) bcnt[c] = 0;
    drive();
    chk("t6 out_valid after reset", ov_a, 1'b0);
    chk("t6 ch0 first ready", ir_a, 4'b0001);
    tick();
    chk("t6 ch0 granted", os_a, 2'd0);
    chk("t6 ch0 valid", ov_a, 1'b1);
    en = '0; drive();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
